// File: rtl/hart_trend_monitor.sv
`default_nettype none
// hart_trend_monitor: debounces a sampled heart-rate value into a reference and
// flags later rises/falls against it (with deadband), plus a staleness indicator.
module hart_trend_monitor #(
  parameter int WIDTH    = 6,
  parameter int DEPTH    = 4,
  parameter int MEM_INIT = 63,
  parameter int HYST     = 0,
  parameter int TIMEOUT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] value,
  input  logic             clear_ref,
  output logic             stable_pulse,
  output logic [WIDTH-1:0] ref_value,
  output logic             rising,
  output logic             falling,
  output logic             stale
);

  localparam int RW = $clog2(DEPTH + 1);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [RW-1:0]    RUN_ZERO  = RW'(0);
  localparam logic [RW-1:0]    RUN_ONE   = RW'(1);
  localparam logic [RW-1:0]    RUN_PRE   = RW'(DEPTH - 1);
  localparam logic [RW-1:0]    RUN_FULL  = RW'(DEPTH);
  localparam logic [WIDTH-1:0] REF_INIT  = WIDTH'(MEM_INIT);
  localparam logic [WIDTH:0]   HYST_X    = (WIDTH + 1)'(HYST);
  localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    STALE_MAX = CW'(TIMEOUT);

  logic [RW-1:0]    run;
  logic [RW-1:0]    run_next;
  logic [WIDTH-1:0] last;
  logic [CW-1:0]    stale_cnt;
  logic             stable_evt;
  logic [WIDTH-1:0] ref_next;
  logic [WIDTH:0]   value_x;
  logic [WIDTH:0]   ref_x;
  logic             rise_next;
  logic             fall_next;

  always_comb begin
    run_next = RUN_ONE;
    if (run != RUN_ZERO && value == last) begin
      run_next = (run == RUN_FULL) ? RUN_FULL : run + RUN_ONE;
    end
    // Only the DEPTH-1 -> DEPTH transition fires; a saturated run stays silent.
    stable_evt = sample_en && (run == RUN_PRE) && (value == last);
    ref_next   = stable_evt ? value : ref_value;
    // One extra bit so ref + HYST and value + HYST cannot wrap at full scale.
    value_x    = {1'b0, value};
    ref_x      = {1'b0, ref_next};
    rise_next  = value_x > (ref_x + HYST_X);
    fall_next  = (value_x + HYST_X) < ref_x;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run          <= RUN_ZERO;
      last         <= '0;
      ref_value    <= REF_INIT;
      rising       <= 1'b0;
      falling      <= 1'b0;
      stable_pulse <= 1'b0;
      stale_cnt    <= CNT_ZERO;
    end else if (clear_ref) begin
      run          <= RUN_ZERO;
      ref_value    <= REF_INIT;
      rising       <= 1'b0;
      falling      <= 1'b0;
      stable_pulse <= 1'b0;
      stale_cnt    <= CNT_ZERO;
    end else begin
      stable_pulse <= stable_evt;
      if (sample_en) begin
        run       <= run_next;
        last      <= value;
        ref_value <= ref_next;
        rising    <= rise_next;
        falling   <= fall_next;
        if (stable_evt) begin
          stale_cnt <= CNT_ZERO;
        end else if (stale_cnt < STALE_MAX) begin
          stale_cnt <= stale_cnt + CNT_ONE;
        end
      end
    end
  end

  assign stale = (TIMEOUT != 0) && (stale_cnt >= STALE_MAX);

endmodule
`default_nettype wire

// File: tb/tb_hart_trend_monitor.sv
`default_nettype none
// Bench for hart_trend_monitor: directed test-plan scenarios with literal checks,
// then randomized traffic, all compared every cycle against a history-based model.
module tb_hart_trend_monitor;

  localparam int WIDTH    = 6;
  localparam int DEPTH    = 4;
  localparam int MEM_INIT = 63;
  localparam int HYST     = 2;
  localparam int TIMEOUT  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             sample_en;
  logic [WIDTH-1:0] value;
  logic             clear_ref;
  logic             stable_pulse;
  logic [WIDTH-1:0] ref_value;
  logic             rising;
  logic             falling;
  logic             stale;

  int n_cmp  = 0;
  int n_fail = 0;

  hart_trend_monitor #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .MEM_INIT(MEM_INIT), .HYST(HYST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .value(value), .clear_ref(clear_ref),
    .stable_pulse(stable_pulse), .ref_value(ref_value), .rising(rising),
    .falling(falling), .stale(stale)
  );

  always #5 clk = ~clk;

  // Model: remembers accepted samples since reset/clear and samples since last stable event.
  int  hist[$];
  int  since_evt;
  int  exp_ref;
  bit  exp_rise, exp_fall, exp_pulse, exp_stale;
  bit  model_valid = 1'b0;

  always @(posedge clk) begin
    model_valid = 1'b1;
    if (!reset || clear_ref) begin
      hist.delete();
      since_evt = 0;
      exp_ref   = MEM_INIT;
      exp_rise  = 1'b0;
      exp_fall  = 1'b0;
      exp_pulse = 1'b0;
    end else if (sample_en) begin
      int  v, n;
      bit  ev;
      v = int'(value);
      hist.push_back(v);
      if (hist.size() > 2 * DEPTH) void'(hist.pop_front());
      n  = hist.size();
      // Stable event: last DEPTH samples equal and the one before them (if any) differs.
      ev = (n >= DEPTH);
      for (int k = 1; k <= DEPTH && k <= n; k++) if (hist[n-k] != v) ev = 1'b0;
      if (ev && n > DEPTH && hist[n-DEPTH-1] == v) ev = 1'b0;
      if (ev) begin
        exp_ref   = v;
        since_evt = 0;
      end else if (since_evt < TIMEOUT) begin
        since_evt = since_evt + 1;
      end
      exp_pulse = ev;
      exp_rise  = v > exp_ref + HYST;
      exp_fall  = v + HYST < exp_ref;
    end else begin
      exp_pulse = 1'b0;
    end
    exp_stale = (TIMEOUT != 0) && (since_evt >= TIMEOUT);
  end

  task automatic cmp(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      cmp("model_pulse", int'(stable_pulse), int'(exp_pulse));
      cmp("model_ref",   int'(ref_value),    exp_ref);
      cmp("model_rise",  int'(rising),       int'(exp_rise));
      cmp("model_fall",  int'(falling),      int'(exp_fall));
      cmp("model_stale", int'(stale),        int'(exp_stale));
    end
  end

  // One strobe; returns at the following negedge with outputs updated.
  task automatic samp(input int v);
    sample_en = 1'b1;
    value     = WIDTH'(v);
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic samp_n(input int v, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      samp(v);
      cmp(name, int'(stable_pulse), 0);
    end
  endtask

  initial begin
    reset     = 1'b0;
    sample_en = 1'b0;
    clear_ref = 1'b0;
    value     = '0;
    repeat (3) @(negedge clk);
    cmp("rst_ref",   int'(ref_value), 63);
    cmp("rst_pulse", int'(stable_pulse), 0);
    cmp("rst_rise",  int'(rising), 0);
    cmp("rst_fall",  int'(falling), 0);
    cmp("rst_stale", int'(stale), 0);
    reset = 1'b1;
    @(negedge clk);

    samp_n(40, 3, "first3_nopulse");
    samp(40);
    cmp("first_pulse", int'(stable_pulse), 1);
    cmp("first_ref",   int'(ref_value), 40);
    @(negedge clk);
    cmp("pulse_one_cycle", int'(stable_pulse), 0);

    samp_n(40, 5, "no_refire");
    samp_n(41, 3, "rearm_pre");
    samp(41);
    cmp("rearm_pulse", int'(stable_pulse), 1);
    cmp("rearm_ref",   int'(ref_value), 41);

    samp_n(40, 3, "back40");
    samp(40);
    cmp("ref40", int'(ref_value), 40);
    samp(42);
    cmp("db42_rise", int'(rising), 0);
    cmp("db42_fall", int'(falling), 0);
    samp(43);
    cmp("db43_rise", int'(rising), 1);
    @(negedge clk);
    cmp("hold_rise", int'(rising), 1);
    samp(37);
    cmp("db37_fall", int'(falling), 1);
    cmp("db37_rise", int'(rising), 0);
    samp(38);
    cmp("db38_rise", int'(rising), 0);
    cmp("db38_fall", int'(falling), 0);

    samp_n(63, 3, "to63");
    samp(63);
    cmp("ref63", int'(ref_value), 63);
    samp(63);
    samp(0);
    cmp("b0_fall", int'(falling), 1);
    samp_n(0, 2, "b0_pre");
    samp(0);
    cmp("b0_pulse", int'(stable_pulse), 1);
    cmp("b0_ref",   int'(ref_value), 0);
    samp(63);
    cmp("b63_rise", int'(rising), 1);
    cmp("b63_fall", int'(falling), 0);

    samp_n(50, 3, "pri_pre");
    clear_ref = 1'b1;
    samp(50);
    clear_ref = 1'b0;
    cmp("pri_ref",   int'(ref_value), 63);
    cmp("pri_pulse", int'(stable_pulse), 0);
    samp_n(50, 3, "pri_post");
    samp(50);
    cmp("pri_pulse4", int'(stable_pulse), 1);
    cmp("pri_ref50",  int'(ref_value), 50);

    for (int i = 0; i < 8; i++) begin
      samp((i % 2 == 0) ? 10 : 11);
      cmp("stale_prog", int'(stale), (i == 7) ? 1 : 0);
    end
    repeat (2) @(negedge clk);
    cmp("stale_hold", int'(stale), 1);
    samp_n(11, 2, "stale_pre");
    samp(11);
    cmp("stale_evt", int'(stable_pulse), 1);
    cmp("stale_clr", int'(stale), 0);

    // Randomized traffic on a narrow value set so episodes occur often.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r         = int'($urandom_range(0, 99));
      reset     = (r != 0);
      clear_ref = ($urandom_range(0, 49) == 0);
      sample_en = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0:       value = '0;
        1:       value = '1;
        2:       value = WIDTH'($urandom);
        default: value = WIDTH'(30 + $urandom_range(0, 2));
      endcase
      @(negedge clk);
    end
    reset = 1'b1; clear_ref = 1'b0; sample_en = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hart_trend_monitor.md
# hart_trend_monitor

Parametrised heart-rate trend monitor: samples a WIDTH-bit rate value on a slow sample strobe and declares the value stable after DEPTH consecutive identical samples. It then latches that value as the reference and flags rises and falls of later samples against the reference, with a configurable deadband. A staleness flag reports when no stable reference has been captured for TIMEOUT samples. It sits between the heart-rate measurement block and the stress/rocking control FSM.

## Interface
- WIDTH, 6: bit width of rate value and reference.
- DEPTH, 4: consecutive equal samples (current included) needed for stability; legal range 2..16.
- MEM_INIT, 63: reference value after reset or clear.
- HYST, 0: deadband in LSBs for rise/fall flags; HYST < 2^WIDTH.
- TIMEOUT, 0: samples without a stable event before `stale` asserts; 0 disables `stale`.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- sample_en  in  1  one-cycle strobe; value is sampled only when high.
- value  in  WIDTH  current heart-rate value.
- clear_ref  in  1  synchronous request to drop the reference and the stability history.
- stable_pulse  out  1  one-cycle pulse when a stable episode begins.
- ref_value  out  WIDTH  current reference.
- rising  out  1  last sample > ref_value + HYST.
- falling  out  1  last sample + HYST < ref_value.
- stale  out  1  no stable event for ≥ TIMEOUT samples.

## Operation
- Reset (reset=0 at clk edge): run=0, last=0, ref_value=MEM_INIT, stale_cnt=0. All outputs are 0 except ref_value.
- Run counter (width clog2(DEPTH+1)): on sample_en, run becomes 1 if run==0 or value!=last, otherwise min(run+1, DEPTH). last is set to value.
- Stable event: on a sample_en where run goes from DEPTH-1 to DEPTH.
  - Fires once per episode. It re-arms only after a differing sample resets run to 1.
  - Holding value constant beyond DEPTH samples produces no further pulses.
- On a stable event: ref_value is set to value, stable_pulse goes high for one cycle, and stale_cnt is set to 0.
- Compare: on every sample_en, rising and falling are recomputed against the post-update reference.
  - Arithmetic uses WIDTH+1 bits, so ref+HYST never wraps.
  - rising and falling are never both 1.
  - On a stable-event sample, both are 0.
- Between strobes, rising and falling hold their value.
- stale_cnt: on each sample_en without a stable event, increments, saturating at TIMEOUT. stale = (TIMEOUT!=0) && (stale_cnt >= TIMEOUT).
- clear_ref (reset=1): run=0, ref_value=MEM_INIT, rising=falling=0, stale_cnt=0, stable_pulse=0.
  - clear_ref has priority over a simultaneous sample_en. That sample is discarded and last is unchanged.
- Reset has priority over clear_ref and sample_en.
- Value changes while sample_en=0 have no effect.

## Timing
- All outputs are registered. Latency is 1 clk from the sample_en edge to updated outputs.
- stable_pulse is high exactly in the cycle after the DEPTH-th equal sample is taken, and ref_value updates on the same edge.
- Back-to-back sample_en (every cycle) is supported at full rate. There is no minimum gap between strobes.
- If reset is asserted mid-episode, the next episode needs a full DEPTH equal samples after release.
- If clear_ref is asserted mid-episode, the next episode likewise needs a full DEPTH equal samples.
- value = 0 and value = 2^WIDTH-1 are legal. Comparisons at these extremes must not overflow.

## Test plan
All scenarios use WIDTH=6, DEPTH=4, MEM_INIT=63, HYST=2, TIMEOUT=8 unless stated.

- **Reset values:** hold reset=0 for 3 clk. Required: ref_value=63, all other outputs 0. Then feed samples 40,40,40. Required: no pulse. A 4th sample of 40 gives stable_pulse for 1 cycle and ref_value=40.
- **No re-fire, then re-arm:** after ref=40, feed 40 ×5. Required: no further pulse. Feed 41, then 41 ×3. Required: pulse on the 4th sample of 41 and ref=41.
- **Deadband:** with ref=40, feed 42 → rising=0, falling=0. Feed 43 → rising=1. Feed 37 → falling=1. Feed 38 → both 0.
- **Boundaries:** with ref=63, feed 63,0,0,0,0. Required: falling=1 after the first 0, then stable_pulse on the 4th 0 and ref=0. Next feed 63 → rising=1, with no wrap errors.
- **Priority:** hold 50 for 3 samples, then assert clear_ref and sample_en together with value 50. Required: ref=63, no pulse, and the next stable pulse only after 4 further samples of 50.
- **Stale:** after a stable event, feed 8 alternating 10/11 samples. Required: stale=1 after the 8th strobe, and it stays 1. The next stable event clears stale the following cycle.
